// File: rtl/tagged_fetch_unit.sv
// rtl/tagged_fetch_unit.sv - fetch stage with BTB/2-bit predictor, return stack and fetch queue
module tagged_fetch_unit #(
  parameter logic [15:0] PC_RESET_VAL = 16'h0,
  parameter int PC_W = 14,
  parameter int BTB_ENTRIES = 8,
  parameter int RAS_DEPTH = 4,
  parameter int FQ_DEPTH = 4,
  localparam int LB = $clog2(BTB_ENTRIES),
  localparam int LR = $clog2(RAS_DEPTH),
  localparam int LQ = $clog2(FQ_DEPTH)
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            upd_valid,
  input  logic [PC_W-1:0] upd_PC,
  input  logic [PC_W-1:0] upd_target,
  input  logic            upd_taken,
  input  logic            take_resolved,
  input  logic [PC_W-1:0] resolved_PC,
  input  logic [LR-1:0]   resolved_RAS_ptr,
  input  logic [LR:0]     resolved_RAS_cnt,
  input  logic            icache_hit,
  input  logic [31:0]     icache_load,
  output logic            icache_REN,
  output logic [31:0]     icache_addr,
  output logic            icache_halt,
  input  logic            core_control_halt,
  output logic            fq_valid,
  input  logic            fq_ready,
  output logic [31:0]     fq_instr,
  output logic [PC_W-1:0] fq_PC,
  output logic [PC_W-1:0] fq_nPC,
  output logic [2*LR:0]   fq_RAS_ckpt
);
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_JAL   = 6'h03;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] FN_JR    = 6'h08;

  logic [PC_W-1:0]    pc;
  logic               halted;
  logic               btb_valid  [BTB_ENTRIES];
  logic [PC_W-LB-1:0] btb_tag    [BTB_ENTRIES];
  logic [PC_W-1:0]    btb_target [BTB_ENTRIES];
  logic [1:0]         btb_state  [BTB_ENTRIES];
  logic [PC_W-1:0]    ras_mem    [RAS_DEPTH];
  logic [LR-1:0]      ras_ptr;
  logic [LR:0]        ras_cnt;
  logic [31:0]        fqm_instr  [FQ_DEPTH];
  logic [PC_W-1:0]    fqm_pc     [FQ_DEPTH];
  logic [PC_W-1:0]    fqm_npc    [FQ_DEPTH];
  logic [2*LR:0]      fqm_ckpt   [FQ_DEPTH];
  logic [LQ-1:0]      fq_head, fq_tail;
  logic [LQ:0]        fq_count;

  logic [5:0]      opcode, funct;
  logic            is_br, is_j, is_jal, is_jr;
  logic [LB-1:0]   idx, uidx;
  logic            btb_hit, upd_match;
  logic [PC_W-1:0] pc_inc, ras_top, npc;
  logic [LR-1:0]   ras_top_ptr;
  logic            fq_full, push_go, pop_go;

  assign opcode      = icache_load[31:26];
  assign funct       = icache_load[5:0];
  assign is_br       = (opcode == OP_BEQ) || (opcode == OP_BNE);
  assign is_jal      = (opcode == OP_JAL);
  assign is_j        = (opcode == OP_J) || is_jal;
  assign is_jr       = (opcode == OP_RTYPE) && (funct == FN_JR);
  assign idx         = pc[LB-1:0];
  assign uidx        = upd_PC[LB-1:0];
  assign btb_hit     = btb_valid[idx] && (btb_tag[idx] == pc[PC_W-1:LB]);
  assign upd_match   = btb_valid[uidx] && (btb_tag[uidx] == upd_PC[PC_W-1:LB]);
  assign pc_inc      = pc + PC_W'(1);
  // ras_ptr names the next free slot, so the top of stack sits one below it
  assign ras_top_ptr = ras_ptr - LR'(1);
  assign ras_top     = ras_mem[ras_top_ptr];

  always_comb begin
    npc = pc_inc;
    if (is_br) begin
      if (btb_hit && btb_state[idx][1]) npc = btb_target[idx];
    end else if (is_j) begin
      npc = icache_load[PC_W-1:0];
    end else if (is_jr) begin
      if (ras_cnt != '0) npc = ras_top;
    end
  end

  assign fq_full     = (fq_count == (LQ+1)'(FQ_DEPTH));
  assign fq_valid    = (fq_count != '0);
  assign icache_REN  = ~halted & ~fq_full;
  assign icache_addr = 32'({pc, 2'b00});
  assign icache_halt = halted;
  assign push_go     = icache_hit & icache_REN & ~take_resolved;
  assign pop_go      = fq_valid & fq_ready & ~take_resolved;

  assign fq_instr    = fqm_instr[fq_head];
  assign fq_PC       = fqm_pc[fq_head];
  assign fq_nPC      = fqm_npc[fq_head];
  assign fq_RAS_ckpt = fqm_ckpt[fq_head];

  always_ff @(posedge CLK) begin
    if (RST) begin
      pc       <= PC_W'(PC_RESET_VAL[15:2]);
      halted   <= 1'b0;
      ras_ptr  <= '0;
      ras_cnt  <= '0;
      fq_head  <= '0;
      fq_tail  <= '0;
      fq_count <= '0;
      for (int i = 0; i < BTB_ENTRIES; i++) begin
        btb_valid[i] <= 1'b0;
        btb_state[i] <= 2'b01;
      end
    end else begin
      if (upd_valid) begin
        btb_valid[uidx]  <= 1'b1;
        btb_tag[uidx]    <= upd_PC[PC_W-1:LB];
        btb_target[uidx] <= upd_target;
        if (!upd_match)
          btb_state[uidx] <= upd_taken ? 2'b10 : 2'b01;
        else if (upd_taken && btb_state[uidx] != 2'b11)
          btb_state[uidx] <= btb_state[uidx] + 2'b01;
        else if (!upd_taken && btb_state[uidx] != 2'b00)
          btb_state[uidx] <= btb_state[uidx] - 2'b01;
      end
      if (core_control_halt) halted <= 1'b1;
      if (take_resolved) begin
        pc       <= resolved_PC;
        ras_ptr  <= resolved_RAS_ptr;
        ras_cnt  <= resolved_RAS_cnt;
        fq_head  <= '0;
        fq_tail  <= '0;
        fq_count <= '0;
      end else begin
        if (push_go) begin
          pc                 <= npc;
          fqm_instr[fq_tail] <= icache_load;
          fqm_pc[fq_tail]    <= pc;
          fqm_npc[fq_tail]   <= npc;
          fqm_ckpt[fq_tail]  <= {ras_ptr, ras_cnt};
          fq_tail            <= fq_tail + LQ'(1);
          if (is_jal) begin
            ras_mem[ras_ptr] <= pc_inc;
            ras_ptr          <= ras_ptr + LR'(1);
            if (ras_cnt != (LR+1)'(RAS_DEPTH)) ras_cnt <= ras_cnt + (LR+1)'(1);
          end else if (is_jr && ras_cnt != '0) begin
            ras_ptr <= ras_top_ptr;
            ras_cnt <= ras_cnt - (LR+1)'(1);
          end
        end
        if (pop_go) fq_head <= fq_head + LQ'(1);
        case ({push_go, pop_go})
          2'b10:   fq_count <= fq_count + (LQ+1)'(1);
          2'b01:   fq_count <= fq_count - (LQ+1)'(1);
          default: fq_count <= fq_count;
        endcase
      end
    end
  end
endmodule
